// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port unified memory arbiter between fetch and data stages
module mem_arbiter #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [A_WIDTH-1:0] if_addr,
  output logic [D_WIDTH-1:0] if_rdata,
  output logic               if_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [A_WIDTH-1:0] d_addr,
  input  logic [D_WIDTH-1:0] d_wdata,
  output logic [D_WIDTH-1:0] d_rdata,
  output logic               d_valid,
  output logic               mem_req,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               stall_f,
  output logic               stall_m
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Which requester completed most recently; breaks ties under contention.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  state_t state, state_nxt;
  last_t  last, last_nxt;

  logic done_i;
  logic done_d;
  logic arb;
  logic elig_i;
  logic elig_d;
  logic grant_i;
  logic grant_d;

  // Completion detection, eligibility masking and the D-first / alternate-on-tie pick.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    done_i    = (state == BUSY_I) && mem_ready;
    done_d    = (state == BUSY_D) && mem_ready;
    // Arbitration happens when idle or on the edge that finishes an access,
    // so a waiting requester is picked up with no bubble cycle.
    arb       = (state == IDLE) || done_i || done_d;
    // The requester just served still shows req high on its completion edge;
    // it must not be granted a second time for the same request.
    elig_i    = if_req && !done_i;
    elig_d    = d_req && !done_d;
    grant_d   = arb && elig_d && (!elig_i || (last == LAST_I));
    grant_i   = arb && elig_i && !grant_d;

    if (done_i) begin
      last_nxt = LAST_I;
    end else if (done_d) begin
      last_nxt = LAST_D;
    end

    if (grant_d) begin
      state_nxt = BUSY_D;
    end else if (grant_i) begin
      state_nxt = BUSY_I;
    end else if (arb) begin
      state_nxt = IDLE;
    end
  end

  // Grant FSM state and tie-break history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= LAST_I;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Memory-side request registers: loaded on a grant, frozen while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= (state_nxt != IDLE);
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (arb) begin
        mem_we <= 1'b0;
      end
    end
  end

  // Result capture and one-cycle completion pulses; stores leave d_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= done_i;
      d_valid  <= done_d;
      if (done_i) begin
        if_rdata <= mem_rdata;
      end
      if (done_d && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  assign stall_f = if_req && !if_valid;
  assign stall_m = d_req && !d_valid;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported unified instruction/data memory between the fetch stage and the memory stage of the pipelined RV32 core. It is built around a three-state grant FSM, registered request latching and a one-cycle result pulse. It produces the per-stage stall signals that the hazard logic uses to freeze the pipeline while an access is outstanding. It sits between the IF/MEM stages and the memory model, replacing the separate instruction and data memories.

## Interface
- A_WIDTH, 32, address width
- D_WIDTH, 32, data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  A_WIDTH  fetch address
- if_rdata  out  D_WIDTH  fetched instruction, registered
- if_valid  out  1  one-cycle pulse: if_rdata valid
- d_req  in  1  data request; held high until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  A_WIDTH  data address
- d_wdata  in  D_WIDTH  store data
- d_rdata  out  D_WIDTH  load data, registered
- d_valid  out  1  one-cycle pulse: data access complete (loads and stores)
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  A_WIDTH  memory address
- mem_wdata  out  D_WIDTH  memory write data
- mem_rdata  in  D_WIDTH  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes current access this cycle
- stall_f  out  1  if_req & ~if_valid (combinational)
- stall_m  out  1  d_req & ~d_valid (combinational)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset (async): state=IDLE, last=I. Outputs mem_req, mem_we, if_valid and d_valid are 0. Registers mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- Arbitration (IDLE, or on a completion edge):
  - Only one requester is eligible: that requester is granted.
  - Both requesters are eligible: data wins unless last=D, in which case fetch wins. This alternates under sustained contention.
- Eligibility: a requester is eligible if its req is high. On a completion edge, the requester just served is ineligible, because its req is still high that cycle.
- Grant: latch addr (plus we and wdata for data; we=0 for fetch) into mem_* registers. Set mem_req=1 and enter BUSY_I or BUSY_D.
- While BUSY_x: mem_* are held constant regardless of changes on the request inputs.
- On a BUSY_x edge with mem_ready=1:
  - Capture mem_rdata into x_rdata. For stores, d_rdata is left unchanged.
  - Pulse x_valid for the next cycle and set last=x.
  - Arbitrate immediately. If another request is granted, go straight to the new BUSY state with mem_req staying 1. Otherwise go to IDLE with mem_req=0 and mem_we=0.
- If a requester drops req mid-access, the access still completes and x_valid still pulses. The requester ignores it.
- mem_req is never high in IDLE. At most one of if_valid and d_valid is high in any cycle.
- Reset mid-access: the access is abandoned, mem_req drops asynchronously and no valid pulse is produced.

## Timing
- Requests are sampled on the rising edge. mem_req and the latched fields are valid from the cycle after the grant.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle): req is sampled at edge 0, mem_req is high in cycle 1, and valid pulses in cycle 2. Minimum latency is 2 cycles.
- Each cycle of mem_ready=0 adds one cycle.
- Back-to-back accesses across requesters have no idle cycle: one memory access per cycle at zero wait.
- stall_f and stall_m drop in the same cycle that the corresponding valid pulses.

## Test plan
- Single fetch, zero wait:
  - Stimulus: if_req=1, if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0050_0093.
  - Required: mem_req high in cycle 1 with mem_addr=0x10 and mem_we=0. if_valid pulses in cycle 2 with if_rdata=0x0050_0093. stall_f=1 in cycles 0–1.
- Store with 2 wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF; mem_ready low for 2 cycles.
  - Required: mem_we=1 and mem_wdata=0xDEADBEEF are held for 3 cycles. d_valid pulses in cycle 4. d_rdata is unchanged.
- Simultaneous requests:
  - Stimulus: if_req=d_req=1 at edge 0, last=I, zero wait.
  - Required: the data access is served in cycle 1 and the fetch in cycle 2 with no idle cycle. d_valid pulses in cycle 2 and if_valid in cycle 3.
- Sustained contention:
  - Stimulus: both requests held for 6 accesses.
  - Required: grants strictly alternate D, I, D, I, D, I.
- Reset mid-access:
  - Stimulus: assert rst while in BUSY_D with mem_ready=0.
  - Required: mem_req=0 immediately, no d_valid, state IDLE. After release, the same pending d_req is re-granted.
- Request withdrawn:
  - Stimulus: drop if_req in cycle 1 of BUSY_I.
  - Required: mem_addr is held, and if_valid still pulses exactly once.
